// File: rtl/if_pkg.sv
// if_pkg: shared widths, default reset PC and fetch-entry type for the fetch stage.
package if_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO with clear and occupancy count; the head entry is always on rdata.
module if_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign do_pop  = pop && count != '0;
    // a full FIFO only takes a write when the head leaves in the same cycle
    assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
    assign rdata   = mem[rptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32IM fetch stage - PC, credit-limited imem requests, redirect kill tracking.
// Defining IF_PERF_CNT_EN adds perf_fetched / perf_stall / perf_killed counters.
module if_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [15:0]     perf_killed
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [XLEN-1:0] fetch_pc, pend_pc;
    logic [CW-1:0] outstanding, fifo_count, kill_cnt;
    logic req_fire, rsp_take, rsp_kill, buf_push, id_pop;
    fetch_entry_t buf_in, buf_out;
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];
    assign id_pop   = id_valid && id_ready;
    assign rsp_take = imem_rsp_valid && outstanding != '0;
    assign rsp_kill = redirect_valid || kill_cnt != '0;
    assign buf_push = rsp_take && !rsp_kill;
    assign buf_in   = '{pc: pend_pc, instr: imem_rsp_data};
    // killed requests still hold credit until they respond, so every response has a slot
    assign imem_req_valid = !rst && !redirect_valid &&
        ({1'b0, outstanding} + {1'b0, fifo_count} < (CW+1)'(FIFO_DEPTH) + (CW+1)'(id_pop));
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign imem_req_addr = fetch_pc;
    assign id_valid      = fifo_count != '0;
    assign id_instr      = id_valid ? buf_out.instr : '0;
    assign id_pc         = id_valid ? buf_out.pc : '0;
    assign id_pc_plus4   = id_valid ? buf_out.pc + 32'd4 : '0;
    if_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pend (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (req_fire),
        .wdata (fetch_pc),
        .pop   (rsp_take),
        .rdata (pend_pc),
        .count (outstanding)
    );
    if_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect_valid),
        .push  (buf_push),
        .wdata (buf_in),
        .pop   (id_pop),
        .rdata (buf_out),
        .count (fifo_count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            kill_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            kill_cnt <= outstanding - CW'(rsp_take);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_take && kill_cnt != '0) kill_cnt <= kill_cnt - CW'(1);
        end
    end
`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_killed  <= '0;
        end else begin
            if (id_pop && !redirect_valid) perf_fetched <= perf_fetched + 32'd1;
            if (id_valid && !id_ready) perf_stall <= perf_stall + 32'd1;
            if (rsp_take && rsp_kill) perf_killed <= perf_killed + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + randomized checks of if_stage against a program-order stream model.
module tb_if_stage;
    import if_pkg::*;
    localparam logic [31:0] RPC = 32'h100;
    localparam int DEPTH = 2;
    logic clk = 0, rst = 0;
    logic imem_req_valid, imem_req_ready = 1, imem_rsp_valid = 0;
    logic [31:0] imem_req_addr, imem_rsp_data = 0;
    logic redirect_valid = 0, id_valid, id_ready = 1;
    logic [31:0] redirect_pc = 0, id_instr, id_pc, id_pc_plus4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
    logic [15:0] perf_killed;
`endif
    if_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_killed(perf_killed)
`endif
    );
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
    mreq_t mq[$];
    int cyc = 0, lat = 1, ep = 0, rsp_ep = 0, live = 0;
    int n_cmp = 0, n_fail = 0, n_hs = 0, n_stall = 0, n_kill = 0;
    int rdy_pct = 100, id_pct = 100, redir_pct = 0;
    logic [31:0] exp_req = RPC, exp_pc = RPC, prev_pc = 0, prev_instr = 0;
    logic prev_stall = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: check/update the model just before the edge, then drive the next cycle's inputs.
    task automatic tick();
        @(negedge clk);
        if (redirect_valid) chk1("no_req_on_redirect", imem_req_valid, 1'b0);
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            mq.push_back('{imem_req_addr, cyc + lat, ep});
            exp_req += 32'd4;
            live++;
        end
        if (prev_stall) begin
            chk1("hold_valid", id_valid, 1'b1);
            chk("hold_pc", id_pc, prev_pc);
            chk("hold_instr", id_instr, prev_instr);
        end
        if (id_valid && id_ready && !redirect_valid) begin
            chk("id_pc", id_pc, exp_pc);
            chk("id_instr", id_instr, instr_of(exp_pc));
            chk("id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
            exp_pc += 32'd4;
            live--;
            n_hs++;
        end
        if (id_valid && !id_ready) n_stall++;
        if (imem_rsp_valid && (redirect_valid || rsp_ep != ep)) n_kill++;
        chk1("credit", live <= DEPTH, 1'b1);
        prev_stall = id_valid && !id_ready && !redirect_valid;
        prev_pc = id_pc;
        prev_instr = id_instr;
        if (redirect_valid) begin
            ep++;
            exp_req = {redirect_pc[31:2], 2'b00};
            exp_pc = exp_req;
            live = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data = instr_of(mq[0].addr);
            rsp_ep = mq[0].ep;
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 0;
            imem_rsp_data = $urandom;
        end
        imem_req_ready = int'($urandom_range(99)) < rdy_pct;
        id_ready = int'($urandom_range(99)) < id_pct;
        if (int'($urandom_range(99)) < redir_pct) begin
            redirect_valid = 1;
            redirect_pc = $urandom;
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1;
        redirect_valid = 0;
        imem_rsp_valid = 0;
        imem_req_ready = 1;
        id_ready = 1;
        #1;
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk1("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        mq.delete();
        exp_req = RPC;
        exp_pc = RPC;
        live = 0;
        prev_stall = 0;
        n_hs = 0;
        n_stall = 0;
        n_kill = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
    endtask

    task automatic perf_check();
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, n_hs);
        chk("perf_stall", perf_stall, n_stall);
        chk("perf_killed", {16'h0, perf_killed}, n_kill & 32'hFFFF);
`endif
    endtask

    task automatic wait_id(input string tag, input logic [31:0] pc);
        int k = 0;
        while (!(id_valid && id_pc == pc) && k < 30) begin
            tick();
            k++;
        end
        chk1({tag, "_seen"}, id_valid, 1'b1);
        chk({tag, "_pc"}, id_pc, pc);
    endtask

    initial begin
        int n0;
        do_reset();
        // first request right after reset release, first instruction two cycles later
        chk1("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, RPC);
        tick();
        chk1("lat_id_empty", id_valid, 1'b0);
        tick();
        chk1("lat_id_valid", id_valid, 1'b1);
        chk("lat_id_pc", id_pc, RPC);
        n0 = n_hs;
        repeat (10) tick();
        chk("throughput", n_hs - n0, 32'd10);
        // decode stall
        id_pct = 0;
        id_ready = 0;
        repeat (5) tick();
        id_pct = 100;
        id_ready = 1;
        repeat (10) tick();
        // slow memory redirect with two stale requests in flight
        lat = 3;
        repeat (8) tick();
        redirect_valid = 1;
        redirect_pc = 32'h203;
        tick();
        n0 = 0;
        while (!imem_req_valid && n0 < 20) begin
            tick();
            n0++;
        end
        chk1("redir3_req_valid", imem_req_valid, 1'b1);
        chk("redir3_req_addr", imem_req_addr, 32'h200);
        wait_id("redir3_first", 32'h200);
        // redirect coinciding with a response and a decode handshake
        lat = 1;
        repeat (6) tick();
        chk1("same_pre_valid", id_valid, 1'b1);
        redirect_valid = 1;
        redirect_pc = 32'h400;
        tick();
        chk1("same_r1_empty", id_valid, 1'b0);
        chk1("same_r1_req", imem_req_valid, 1'b1);
        chk("same_r1_addr", imem_req_addr, 32'h400);
        tick();
        chk1("same_r2_empty", id_valid, 1'b0);
        tick();
        chk1("same_r3_valid", id_valid, 1'b1);
        chk("same_r3_pc", id_pc, 32'h400);
        // PC wrap
        repeat (3) tick();
        redirect_valid = 1;
        redirect_pc = 32'hFFFF_FFFB;
        tick();
        chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr2", imem_req_addr, 32'h0);
        tick();
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", id_pc_plus4, 32'h0);
        repeat (5) tick();
        perf_check();
        // randomized traffic
        rdy_pct = 70;
        id_pct = 70;
        redir_pct = 4;
        for (int r = 0; r < 6; r++) begin
            lat = 1 + r % 4;
            repeat (200) tick();
        end
        perf_check();
        // reset in the middle of traffic
        redir_pct = 0;
        rdy_pct = 100;
        id_pct = 100;
        do_reset();
        chk1("rerst_req_valid", imem_req_valid, 1'b1);
        chk("rerst_req_addr", imem_req_addr, RPC);
        wait_id("rerst_first", RPC);
        rdy_pct = 60;
        id_pct = 60;
        redir_pct = 3;
        repeat (400) tick();
        perf_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage for the RV32IM pipeline: owns the program counter, issues in-order word fetches to instruction memory over a valid/ready request channel, buffers returned instructions with their PCs, and presents them one at a time to the decode stage. It is the block directly upstream of decode. It also accepts redirects (taken branch, JAL, JALR) from the execute stage and discards any wrong-path fetches still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the outstanding-plus-buffered credit limit. Minimum 2, power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; in order; no backpressure.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  redirect from execute; single-cycle pulse.
- redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to zero.
- id_valid  output  1  instruction available to decode.
- id_ready  input  1  decode accepts this cycle.
- id_instr  output  32  instruction to decode.
- id_pc  output  32  PC of id_instr.
- id_pc_plus4  output  32  id_pc + 4, modulo 2^32.

## Operation
- fetch_pc: next address to request. It increments by 4 on each request handshake (imem_req_valid && imem_req_ready) and wraps modulo 2^32.
- Pending-PC queue (FIFO_DEPTH entries) records the address of each accepted request. Each response pops one PC and pushes {pc, instr} into the instruction FIFO, unless the response is killed.
- Credit rule: imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH + pop), where pop = id_valid && id_ready.
  - This guarantees buffer space for every response, so the response channel needs no ready signal.
- outstanding counts all accepted requests that have not yet responded, including killed ones.
- Modes:
  - FETCH: kill_cnt == 0.
  - DRAIN: kill_cnt > 0. Each response arriving in DRAIN is dropped, pops its pending PC, and decrements kill_cnt.
  - New requests are allowed in both modes.
- Redirect cycle:
  - Instruction FIFO is cleared.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No request is issued.
  - kill_cnt <= outstanding minus any response dropped in that same cycle.
  - Responses arriving in the redirect cycle are dropped.
  - A decode handshake in the redirect cycle is ignored; the entry is flushed.
- Redirect during DRAIN: kill_cnt is recomputed from the current outstanding count.
- Stall: while id_valid && !id_ready, id_instr, id_pc and id_pc_plus4 hold stable.
- Simultaneous push and pop on a full FIFO is legal and the count is unchanged. The credit rule prevents a push to a full FIFO without a pop.

## Timing
- Reset values:
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - id_valid = 0, id_instr = 0, id_pc = 0, id_pc_plus4 = 0.
  - fetch_pc = RESET_PC; all counters and queues empty.
- First request is asserted in the first cycle after rst deasserts.
- Reset mid-operation drops all state immediately. Responses to pre-reset requests are not tracked; the memory is reset with the same rst.
- Response to decode latency: a response in cycle N is visible on id_valid in cycle N+1 (registered FIFO output).
- With a 1-cycle memory, imem_req_ready=1 and id_ready=1, throughput is one instruction per cycle.
- Redirect in cycle R: first request to the target in cycle R+1; the earliest target instruction reaches id_valid in R+3 with a 1-cycle memory.

## Configuration
- IF_PERF_CNT_EN defined adds three outputs:
  - perf_fetched (32-bit): counts decode handshakes.
  - perf_stall (32-bit): counts cycles with id_valid && !id_ready.
  - perf_killed (16-bit): counts dropped responses.
  - All three reset to 0, wrap on overflow, and must not affect functional behaviour.
- IF_PERF_CNT_EN undefined: the ports and counters are absent.

## Structure
- Shared package if_pkg holds:
  - default RESET_PC
  - XLEN = 32
  - ILEN = 32
  - NOP = 32'h0000_0013
  - fetch-entry struct {pc, instr}.
- One sub-module, if_fifo: a synchronous FIFO with parameterised width and depth, a clear input, and count output. It is instantiated for both the pending-PC queue and the instruction buffer.

## Test plan
- Reset with RESET_PC=32'h100, 1-cycle memory, id_ready=1 -> requests to 100, 104, 108 on consecutive cycles; id_pc 100, 104, 108 starting 2 cycles after the first request.
- id_ready held low for 5 cycles after the first instruction -> at most FIFO_DEPTH accepted requests outstanding or buffered; id_instr/id_pc stable; no instruction lost or duplicated on release.
- 3-cycle memory latency, 2 requests outstanding, redirect_pc=32'h203 -> next request addr 200; both stale responses dropped; first id_pc after redirect is 200.
- Redirect in the same cycle as a response and a decode handshake -> FIFO empty next cycle; no request in the redirect cycle; the stale response is not delivered.
- fetch_pc = 32'hFFFF_FFFC -> next request addr 0; id_pc_plus4 = 0 for that instruction.
- With IF_PERF_CNT_EN: 10 instructions delivered, 4 stall cycles, 2 killed responses -> perf_fetched=10, perf_stall=4, perf_killed=2.
